spi_readout_slave: RTL and testbench



---
 rtl/spi_readout_slave.sv | 109 ++++++++++
 tb/tb_spi_readout_slave.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spi_readout_slave.sv
// spi_readout_slave: mode-0 SPI slave streaming a status header then 24-bit words, oversampled in clk.
module spi_readout_slave #(
  parameter int          WORD_W      = 24,
  parameter logic [3:0]  HDR_SYNC    = 4'hA,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [WORD_W-1:0] word_in,
  input  logic              int_raw,
  input  logic              int_peak,
  output logic              word_req,
  output logic              irq,
  output logic              frame_active
);
  localparam int CW = $clog2(WORD_W + 1);
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] cs_sr, sclk_sr;
  logic cs_d, sclk_d, cs_s, sclk_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [WORD_W-1:0] shift_reg, shift_n;
  logic [CW-1:0] bit_cnt, cnt_n;
  logic miso_n, fa_n, req_n, word_valid, wv_n;
  assign cs_s      = cs_sr[SYNC_STAGES-1];
  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cs_sr        <= '1;
      sclk_sr      <= '0;
      cs_d         <= 1'b1;
      sclk_d       <= 1'b0;
      state        <= IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      spi_miso     <= 1'b0;
      spi_miso_oe  <= 1'b0;
      word_req     <= 1'b0;
      irq          <= 1'b0;
      frame_active <= 1'b0;
      word_valid   <= 1'b0;
    end else begin
      cs_sr        <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n};
      sclk_sr      <= {sclk_sr[SYNC_STAGES-2:0], spi_sclk};
      cs_d         <= cs_s;
      sclk_d       <= sclk_s;
      state        <= state_n;
      shift_reg    <= shift_n;
      bit_cnt      <= cnt_n;
      spi_miso     <= miso_n;
      spi_miso_oe  <= ~cs_s;
      word_req     <= req_n;
      irq          <= int_raw | int_peak;
      frame_active <= fa_n;
      word_valid   <= wv_n;
    end
  // Header sits top-aligned so header and data share one MSB-first shift path.
  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    cnt_n   = bit_cnt;
    miso_n  = spi_miso;
    fa_n    = frame_active;
    wv_n    = word_valid;
    req_n   = 1'b0;
    if (cs_rise) begin
      state_n = IDLE;
      fa_n    = 1'b0;
      miso_n  = 1'b0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: if (cs_fall) begin
          shift_n = {int_raw, int_peak, 2'b00, HDR_SYNC, {(WORD_W-8){1'b0}}};
          miso_n  = int_raw;
          cnt_n   = '0;
          fa_n    = 1'b1;
          state_n = HDR;
        end
        HDR, DATA: begin
          if (sclk_rise) begin
            cnt_n = bit_cnt + 1'b1;
            req_n = (state == DATA) && word_valid && (bit_cnt == CW'(WORD_W - 1));
          end else if (sclk_fall) begin
            if (bit_cnt == ((state == HDR) ? CW'(8) : CW'(WORD_W))) begin
              shift_n = word_in;
              miso_n  = word_in[WORD_W-1];
              wv_n    = int_raw | int_peak;
              cnt_n   = '0;
              state_n = DATA;
            end else begin
              shift_n = shift_reg << 1;
              miso_n  = shift_reg[WORD_W-2];
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_readout_slave.sv
// tb_spi_readout_slave: host/upstream model driving SPI frames and checking the serial stream and word requests.
module tb_spi_readout_slave;
  logic clk = 0, rst = 1, spi_cs_n = 1, spi_sclk = 0, int_raw = 0, int_peak = 0;
  logic spi_miso, spi_miso_oe, word_req, irq, frame_active;
  logic [23:0] word_in = '0, junk;
  logic [23:0] q[$], lst[$];
  logic [127:0] cap;
  logic req_prev = 0;
  int checks = 0, errors = 0, req_pulses = 0, req_cycles = 0;

  spi_readout_slave dut (
    .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .word_in(word_in),
    .int_raw(int_raw), .int_peak(int_peak), .word_req(word_req),
    .irq(irq), .frame_active(frame_active)
  );

  always #5 clk = ~clk;

  // upstream buffer: advances to the next queued word on every request
  always @(posedge clk) begin
    if (!rst) begin
      if (word_req) req_cycles++;
      if (word_req && !req_prev) req_pulses++;
      if (word_req && q.size() > 0) begin
        junk = q.pop_front();
        word_in <= (q.size() > 0) ? q[0] : '0;
      end
    end
    req_prev <= word_req;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [23:0] words[$]);
    q = words;
    word_in = (q.size() > 0) ? q[0] : '0;
    req_pulses = 0;
    req_cycles = 0;
  endtask

  task automatic bits(input int n, input int h);
    for (int i = 0; i < n; i++) begin
      cap = {cap[126:0], spi_miso};
      spi_sclk = 1;
      tick(h);
      spi_sclk = 0;
      tick(h);
    end
  endtask

  task automatic frame(input int n, input int h);
    cap = '0;
    spi_cs_n = 0;
    tick(6);
    check("frame_active_on", frame_active, 1);
    check("miso_oe_on", spi_miso_oe, 1);
    bits(n, h);
    spi_cs_n = 1;
    tick(8);
    check("frame_active_off", {frame_active, spi_miso_oe, spi_miso}, 0);
  endtask

  function automatic logic [23:0] word_at(input int n, input int k);
    return cap[n-9-24*k -: 24];
  endfunction

  initial begin
    logic [7:0] hdr;
    logic valid;
    int nw, tail, h, n;
    tick(3);
    rst = 0;
    tick(3);
    check("reset_outputs", {spi_miso, spi_miso_oe, word_req, irq, frame_active}, 0);

    // header and single word
    int_raw = 1; int_peak = 0;
    load('{24'hABC123});
    frame(32, 4);
    check("hdr_single", cap[31:24], 8'h8A);
    check("word_single", word_at(32, 0), 24'hABC123);
    check("req_single", req_pulses, 1);
    check("req_width_single", req_cycles, 1);

    // multi-word burst
    load('{24'h000001, 24'h000002, 24'h000003});
    frame(80, 4);
    for (int k = 0; k < 3; k++) check("word_burst", word_at(80, k), k + 1);
    check("req_burst", req_pulses, 3);
    check("req_width_burst", req_cycles, 3);

    // aborted word is neither requested nor lost
    load('{24'h5A5A5A, 24'h0F0F0F});
    frame(20, 4);
    check("req_abort", req_pulses, 0);
    check("queue_abort", q.size(), 2);
    frame(32, 5);
    check("word_resend", word_at(32, 0), 24'h5A5A5A);
    check("req_resend", req_pulses, 1);

    // no data
    int_raw = 0; int_peak = 0;
    load('{});
    frame(32, 4);
    check("hdr_empty", cap[31:24], 8'h0A);
    check("word_empty", word_at(32, 0), 0);
    check("req_empty", req_pulses, 0);
    check("irq_empty", irq, 0);

    // interrupt latency
    int_peak = 1;
    check("irq_before_edge", irq, 0);
    tick(1);
    check("irq_after_edge", irq, 1);
    int_peak = 0;
    tick(2);

    // sclk activity with cs high must be ignored
    for (int i = 0; i < 6; i++) begin
      spi_sclk = ~spi_sclk;
      tick(4);
      check("idle_sclk", {spi_miso, spi_miso_oe, frame_active}, 0);
    end
    spi_sclk = 0;
    tick(4);
    int_raw = 1;
    load('{24'h13579B});
    frame(32, 4);
    check("hdr_after_idle", cap[31:24], 8'h8A);
    check("word_after_idle", word_at(32, 0), 24'h13579B);

    // reset mid-frame after 5 data bits
    load('{24'hFFFFFF});
    spi_cs_n = 0;
    tick(6);
    bits(13, 4);
    check("miso_before_rst", spi_miso, 1);
    rst = 1;
    #1;
    check("rst_midframe", {spi_miso, spi_miso_oe, frame_active}, 0);
    spi_cs_n = 1;
    tick(4);
    rst = 0;
    tick(4);
    check("req_rst", req_pulses, 0);
    frame(32, 4);
    check("hdr_after_rst", cap[31:24], 8'h8A);
    check("word_after_rst", word_at(32, 0), 24'hFFFFFF);

    // randomized frames against the stream model
    for (int f = 0; f < 8; f++) begin
      int_raw = 1'($urandom);
      int_peak = 1'($urandom);
      valid = int_raw | int_peak;
      hdr = {int_raw, int_peak, 2'b00, 4'hA};
      nw = $urandom_range(1, 3);
      tail = $urandom_range(0, 23);
      h = $urandom_range(4, 6);
      lst = {};
      for (int k = 0; k <= nw; k++) lst.push_back(24'($urandom));
      load(lst);
      n = 8 + 24 * nw + tail;
      frame(n, h);
      check("hdr_rand", cap[n-1 -: 8], hdr);
      // an unrequested word is never advanced, so the first word repeats
      for (int k = 0; k < nw; k++)
        check("word_rand", cap[n-9-24*k -: 24], valid ? lst[k] : lst[0]);
      check("req_rand", req_pulses, valid ? nw : 0);
      check("req_width_rand", req_cycles, valid ? nw : 0);
      check("queue_rand", q.size(), valid ? 1 : nw + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
